// File: rtl/seq_divmod_if.sv
// Request/response channel of the iterative divider.
//   master : ALU-side controller (drives requests, consumes responses)
//   slave  : divider (accepts requests, produces responses)
// Signals:
//   in_valid/in_ready    request handshake
//   dividend/divisor     request operands, sampled on in_valid && in_ready
//   out_valid/out_ready  response handshake
//   quotient/remainder   response results
//   div_by_zero          response was produced for a zero divisor
interface seq_divmod_if #(
    parameter int unsigned BITS = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] dividend;
    logic [BITS-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] quotient;
    logic [BITS-1:0] remainder;
    logic            div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divmod.sv
// Iterative unsigned divider: restoring division, MSB first, one quotient bit
// per clock. A zero divisor skips the iterations and answers on the next cycle
// with quotient = all-ones, remainder = dividend and div_by_zero set.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_divmod_if.slave request/response channel
module seq_divmod #(
    parameter int unsigned BITS = 8
) (
    input logic         clk,
    input logic         rst_n,
    seq_divmod_if.slave bus
);

    localparam int unsigned CW = $clog2(BITS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] work_q;     // dividend bits shifting out, quotient bits shifting in
    logic [BITS-1:0] dvs_q;
    logic [BITS-1:0] rem_q;      // partial remainder, always < divisor between steps
    logic [BITS-1:0] quo_q;
    logic [BITS-1:0] rmd_q;
    logic            dbz_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic            accept_c;
    logic            last_c;
    logic [BITS:0]   r_shift_c;  // extra bit keeps the shifted remainder from overflowing
    logic            ge_c;
    logic [BITS-1:0] r_next_c;
    logic [BITS-1:0] q_next_c;

    // Next state plus one restoring-division step
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        r_shift_c = {rem_q, work_q[BITS-1]};
        ge_c      = (r_shift_c >= {1'b0, dvs_q});
        r_next_c  = ge_c ? BITS'(r_shift_c - {1'b0, dvs_q}) : r_shift_c[BITS-1:0];
        q_next_c  = {work_q[BITS-2:0], ge_c};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(BITS - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            rmd_q       <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);

            if (accept_c) begin
                work_q <= bus.dividend;
                dvs_q  <= bus.divisor;
                rem_q  <= '0;
                cnt_q  <= '0;
                if (bus.divisor == '0) begin
                    quo_q <= '1;
                    rmd_q <= bus.dividend;
                    dbz_q <= 1'b1;
                end
            end else if (state_q == RUN) begin
                work_q <= q_next_c;
                rem_q  <= r_next_c;
                cnt_q  <= cnt_q + CW'(1);
                if (last_c) begin
                    quo_q <= q_next_c;
                    rmd_q <= r_next_c;
                    dbz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed testbench for seq_divmod (BITS = 8).
module tb_seq_divmod;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    seq_divmod_if #(.BITS(8)) bus ();

    seq_divmod #(.BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present a request until accepted; t0 = cycle count sampled just after the accept edge
    task automatic send(input logic [7:0] a, input logic [7:0] b, output int t0, output bit ok);
        ok = 1'b0;
        t0 = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.in_ready) begin
                @(posedge clk); #1;
                t0 = cyc;
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; t = cycle count when first seen
    task automatic wait_out(output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.out_valid) begin
                t  = cyc;
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    // One full transaction with out_ready high; returns results and latency in edges
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic dbz,
                          output int lat, output bit ok);
        int  t0, t1;
        bit  ok0, ok1;
        bus.out_ready = 1'b1;
        send(a, b, t0, ok0);
        wait_out(t1, ok1);
        ok  = ok0 && ok1;
        lat = t1 - t0;
        q   = bus.quotient;
        r   = bus.remainder;
        dbz = bus.div_by_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b%b expected 10", bus.in_ready, bus.out_valid);
        end
        tests++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs: q=%0d r=%0d dbz=%b expected 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] q, r;
        logic       dbz;
        int         lat;
        bit         ok;
        run_op(8'd200, 8'd7, q, r, dbz, lat, ok);
        tests++;
        if (!ok || lat != 8) begin
            fails++;
            $display("FAIL basic_latency: ok=%b latency=%0d expected 8", ok, lat);
        end
        tests++;
        if ({q, r, dbz} !== {8'd28, 8'd4, 1'b0}) begin
            fails++;
            $display("FAIL basic_200_7: q=%0d r=%0d dbz=%b expected 28 4 0", q, r, dbz);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [4] = '{8'd255, 8'd3,  8'd255, 8'd0};
        logic [7:0] tb [4] = '{8'd1,   8'd10, 8'd255, 8'd5};
        logic [7:0] tq [4] = '{8'd255, 8'd0,  8'd1,   8'd0};
        logic [7:0] tr [4] = '{8'd0,   8'd3,  8'd0,   8'd0};
        logic [7:0] q, r;
        logic       dbz;
        int         lat;
        bit         ok;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, dbz, lat, ok);
            tests++;
            if (!ok || lat != 8 || {q, r, dbz} !== {tq[i], tr[i], 1'b0}) begin
                fails++;
                $display("FAIL boundary_%0d_%0d: ok=%b lat=%0d q=%0d r=%0d dbz=%b expected lat 8 q=%0d r=%0d dbz=0",
                         ta[i], tb[i], ok, lat, q, r, dbz, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r;
        logic       dbz;
        int         lat;
        bit         ok;
        // Zero divisor goes straight to DONE on the accept edge
        run_op(8'd5, 8'd0, q, r, dbz, lat, ok);
        tests++;
        if (!ok || lat != 0) begin
            fails++;
            $display("FAIL dbz_latency: ok=%b latency=%0d expected 0 edges after accept", ok, lat);
        end
        tests++;
        if ({q, r, dbz} !== {8'hFF, 8'd5, 1'b1}) begin
            fails++;
            $display("FAIL dbz_5_0: q=%0h r=%0d dbz=%b expected ff 5 1", q, r, dbz);
        end
        run_op(8'd9, 8'd3, q, r, dbz, lat, ok);
        tests++;
        if (!ok || {q, r, dbz} !== {8'd3, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL dbz_clear_9_3: ok=%b q=%0d r=%0d dbz=%b expected 3 0 0", ok, q, r, dbz);
        end
    endtask

    task automatic test_backpressure();
        int t0, t1;
        bit ok0, ok1;
        bus.out_ready = 1'b0;
        send(8'd100, 8'd9, t0, ok0);
        wait_out(t1, ok1);
        tests++;
        if (!ok0 || !ok1 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd11, 8'd1, 1'b0}) begin
            fails++;
            $display("FAIL bp_result: ok=%b%b q=%0d r=%0d dbz=%b expected 11 1 0",
                     ok0, ok1, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        // A competing request while the response is stalled must be ignored
        bus.dividend = 8'd1;
        bus.divisor  = 8'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero}
                    !== {1'b1, 1'b0, 8'd11, 8'd1, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b q=%0d r=%0d dbz=%b expected 1 0 11 1 0",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({bus.out_valid, bus.in_ready, bus.quotient} !== {1'b0, 1'b1, 8'd11}) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b q=%0d expected 0 1 11",
                     bus.out_valid, bus.in_ready, bus.quotient);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] q, r;
        logic       dbz;
        int         t0, lat;
        bit         ok;
        bus.out_ready = 1'b1;
        send(8'd77, 8'd5, t0, ok);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (!ok || {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero}
                !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL midrun_reset: ok=%b out_valid=%b in_ready=%b q=%0d r=%0d dbz=%b expected 0 1 0 0 0",
                     ok, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd77, 8'd5, q, r, dbz, lat, ok);
        tests++;
        if (!ok || lat != 8 || {q, r, dbz} !== {8'd15, 8'd2, 1'b0}) begin
            fails++;
            $display("FAIL midrun_retry_77_5: ok=%b lat=%0d q=%0d r=%0d dbz=%b expected 8 15 2 0", ok, lat, q, r, dbz);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [10] = '{8'd200, 8'd13, 8'd0,  8'd254, 8'd99,  8'd128, 8'd255, 8'd17, 8'd250, 8'd181};
        logic [7:0] vb [10] = '{8'd7,   8'd13, 8'd9,  8'd3,   8'd100, 8'd2,   8'd16,  8'd5,  8'd251, 8'd12};
        logic [7:0] qs, rs, eq, er;
        logic       ds, acc, rsp;
        int         nacc, nresp, last_acc;
        nacc     = 0;
        nresp    = 0;
        last_acc = 0;
        bus.out_ready = 1'b1;
        bus.dividend  = va[0];
        bus.divisor   = vb[0];
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 300 && nresp < 10; c++) begin
            acc = bus.in_valid && bus.in_ready;
            rsp = bus.out_valid && bus.out_ready;
            qs  = bus.quotient;
            rs  = bus.remainder;
            ds  = bus.div_by_zero;
            @(posedge clk); #1;
            if (acc) begin
                if (nacc > 0) begin
                    tests++;
                    if (cyc - last_acc != 10) begin
                        fails++;
                        $display("FAIL b2b_spacing_%0d: accept interval=%0d expected 10", nacc, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                nacc++;
                if (nacc < 10) begin
                    bus.dividend = va[nacc];
                    bus.divisor  = vb[nacc];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (rsp) begin
                eq = va[nresp] / vb[nresp];
                er = va[nresp] % vb[nresp];
                tests++;
                if ({qs, rs, ds} !== {eq, er, 1'b0}) begin
                    fails++;
                    $display("FAIL b2b_result_%0d_%0d: q=%0d r=%0d dbz=%b expected %0d %0d 0",
                             va[nresp], vb[nresp], qs, rs, ds, eq, er);
                end
                nresp++;
            end
        end
        bus.in_valid = 1'b0;
        tests++;
        if (nacc != 10 || nresp != 10) begin
            fails++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d expected 10 10", nacc, nresp);
        end
    endtask

    initial begin
        cyc   = 0;
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
